// File: rtl/grf.sv
// 2**DEPTH_LOG2 x WIDTH MIPS general register file with two read ports, one write port and a debug port.
// Latency: reads are combinational, with an optional write-through bypass; writes commit on the rising edge.
// Backpressure: none; a write is accepted on every edge where RegWrite=1.
module grf #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 5,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [DEPTH_LOG2-1:0] Reg_rs,
    input  logic [DEPTH_LOG2-1:0] Reg_rt,
    input  logic [DEPTH_LOG2-1:0] Reg_rd,
    input  logic [WIDTH-1:0]      WData,
    output logic [WIDTH-1:0]      RData1,
    output logic [WIDTH-1:0]      RData2,
    input  logic [DEPTH_LOG2-1:0] Dbg_idx,
    output logic [WIDTH-1:0]      Dbg_data,
    output logic                  WB_valid,
    output logic [DEPTH_LOG2-1:0] WB_idx,
    output logic [WIDTH-1:0]      WB_data
);

    localparam int NREG = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] regs [NREG];
    logic             wr_en;

    // Writes to $0 are dropped here, so regs[0] never leaves its reset value.
    assign wr_en = RegWrite && (Reg_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[Reg_rd] <= WData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_valid <= 1'b0;
            WB_idx   <= '0;
            WB_data  <= '0;
        end else begin
            WB_valid <= wr_en;
            if (wr_en) begin
                WB_idx  <= Reg_rd;
                WB_data <= WData;
            end
        end
    end

    // Each read port resolves independently; the bypass only applies to a write that will actually commit.
    always_comb begin
        RData1 = '0;
        if (rst_n && (Reg_rs != '0)) begin
            if ((BYPASS != 0) && wr_en && (Reg_rs == Reg_rd)) begin
                RData1 = WData;
            end else begin
                RData1 = regs[Reg_rs];
            end
        end
    end

    always_comb begin
        RData2 = '0;
        if (rst_n && (Reg_rt != '0)) begin
            if ((BYPASS != 0) && wr_en && (Reg_rt == Reg_rd)) begin
                RData2 = WData;
            end else begin
                RData2 = regs[Reg_rt];
            end
        end
    end

    always_comb begin
        Dbg_data = '0;
        if (rst_n && (Dbg_idx != '0)) begin
            Dbg_data = regs[Dbg_idx];
        end
    end

    // An unknown write enable outside reset would silently skip or corrupt a write.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown(RegWrite)) else $error("grf: RegWrite is unknown at clock edge");
        end
    end

endmodule

// File: tb/tb_grf.sv
// Directed bench for grf: a bypassing and a non-bypassing instance share stimulus; expectations go through a scoreboard queue.
module tb_grf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  Reg_rs, Reg_rt, Reg_rd, Dbg_idx;
    logic [31:0] WData;
    logic [31:0] RData1, RData2, Dbg_data, WB_data;
    logic        WB_valid;
    logic [4:0]  WB_idx;
    logic [31:0] d0_RData1, d0_RData2, d0_Dbg_data, d0_WB_data;
    logic        d0_WB_valid;
    logic [4:0]  d0_WB_idx;

    int n_assert = 0;
    int n_fail   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    grf #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
        .Reg_rs(Reg_rs), .Reg_rt(Reg_rt), .Reg_rd(Reg_rd), .WData(WData),
        .RData1(RData1), .RData2(RData2), .Dbg_idx(Dbg_idx), .Dbg_data(Dbg_data),
        .WB_valid(WB_valid), .WB_idx(WB_idx), .WB_data(WB_data)
    );

    grf #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
        .Reg_rs(Reg_rs), .Reg_rt(Reg_rt), .Reg_rd(Reg_rd), .WData(WData),
        .RData1(d0_RData1), .RData2(d0_RData2), .Dbg_idx(Dbg_idx), .Dbg_data(d0_Dbg_data),
        .WB_valid(d0_WB_valid), .WB_idx(d0_WB_idx), .WB_data(d0_WB_data)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (val_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; RegWrite = 1'b0; Reg_rs = 5'd7; Reg_rt = 5'd0; Reg_rd = 5'd0;
        Dbg_idx = 5'd0; WData = 32'h0;

        // Reset state
        #12;
        expect_val("rst_wb_valid", 32'd0); chk({31'd0, WB_valid});
        expect_val("rst_wb_idx", 32'd0);   chk({27'd0, WB_idx});
        expect_val("rst_wb_data", 32'd0);  chk(WB_data);
        expect_val("rst_rdata1", 32'd0);   chk(RData1);
        @(negedge clk); rst_n = 1'b1;

        // Mid-run reset clears a written register immediately
        @(negedge clk); RegWrite = 1'b1; Reg_rd = 5'd5; WData = 32'h1234;
        tick(); RegWrite = 1'b0; Reg_rs = 5'd5; #1;
        expect_val("r5_written", 32'h1234); chk(RData1);
        expect_val("r5_wb_valid", 32'd1);   chk({31'd0, WB_valid});
        rst_n = 1'b0; #1;
        expect_val("rst_async_rdata1", 32'd0); chk(RData1);
        expect_val("rst_async_wb_valid", 32'd0); chk({31'd0, WB_valid});
        @(negedge clk); rst_n = 1'b1;

        // Basic write/read
        @(negedge clk); RegWrite = 1'b1; Reg_rd = 5'd8; WData = 32'hDEADBEEF;
        tick(); RegWrite = 1'b0; Reg_rs = 5'd8; Reg_rt = 5'd8; #1;
        expect_val("basic_rdata1", 32'hDEADBEEF); chk(RData1);
        expect_val("basic_rdata2", 32'hDEADBEEF); chk(RData2);
        expect_val("basic_wb_valid", 32'd1);      chk({31'd0, WB_valid});
        expect_val("basic_wb_idx", 32'd8);        chk({27'd0, WB_idx});
        expect_val("basic_wb_data", 32'hDEADBEEF); chk(WB_data);
        tick();
        expect_val("basic_wb_pulse_end", 32'd0);  chk({31'd0, WB_valid});
        expect_val("basic_wb_idx_hold", 32'd8);   chk({27'd0, WB_idx});

        // $0 protection, including no bypass of a write to $0
        RegWrite = 1'b1; Reg_rd = 5'd0; WData = 32'hFFFFFFFF; Reg_rs = 5'd0; Dbg_idx = 5'd0; #1;
        expect_val("r0_no_bypass", 32'd0); chk(RData1);
        tick(); RegWrite = 1'b0; #1;
        expect_val("r0_rdata1", 32'd0);   chk(RData1);
        expect_val("r0_dbg", 32'd0);      chk(Dbg_data);
        expect_val("r0_wb_valid", 32'd0); chk({31'd0, WB_valid});

        // Bypass versus stored value
        RegWrite = 1'b1; Reg_rd = 5'd3; WData = 32'h11;
        tick(); Reg_rd = 5'd3; WData = 32'h22; Reg_rs = 5'd3; Reg_rt = 5'd3; Dbg_idx = 5'd3; #1;
        expect_val("bypass_rdata1", 32'h22);    chk(RData1);
        expect_val("bypass_rdata2", 32'h22);    chk(RData2);
        expect_val("bypass_dbg_old", 32'h11);   chk(Dbg_data);
        expect_val("nobypass_rdata1", 32'h11);  chk(d0_RData1);
        expect_val("nobypass_rdata2", 32'h11);  chk(d0_RData2);
        tick(); RegWrite = 1'b0; #1;
        expect_val("bypass_committed", 32'h22);   chk(RData1);
        expect_val("nobypass_committed", 32'h22); chk(d0_RData1);

        // Back-to-back writes
        RegWrite = 1'b1; Reg_rd = 5'd1; WData = 32'd1;
        tick(); Reg_rd = 5'd1; WData = 32'd2;
        expect_val("b2b_v0", 32'd1);   chk({31'd0, WB_valid});
        expect_val("b2b_idx0", 32'd1); chk({27'd0, WB_idx});
        tick(); Reg_rd = 5'd2; WData = 32'd3;
        expect_val("b2b_v1", 32'd1);   chk({31'd0, WB_valid});
        expect_val("b2b_idx1", 32'd1); chk({27'd0, WB_idx});
        expect_val("b2b_data1", 32'd2); chk(WB_data);
        tick(); RegWrite = 1'b0; Reg_rs = 5'd1; Reg_rt = 5'd2; #1;
        expect_val("b2b_v2", 32'd1);   chk({31'd0, WB_valid});
        expect_val("b2b_idx2", 32'd2); chk({27'd0, WB_idx});
        expect_val("b2b_r1", 32'd2);   chk(RData1);
        expect_val("b2b_r2", 32'd3);   chk(RData2);
        tick();
        expect_val("b2b_v_end", 32'd0); chk({31'd0, WB_valid});

        // Async reset asserted between edges while a write is pending, held across an edge
        RegWrite = 1'b1; Reg_rd = 5'd9; WData = 32'hABC;
        @(negedge clk); #2; rst_n = 1'b0;
        tick();
        expect_val("rst_pulse_wb_valid", 32'd0); chk({31'd0, WB_valid});
        expect_val("rst_pulse_rdata_r9", 32'd0); Reg_rs = 5'd9; #1; chk(RData1);
        @(negedge clk); RegWrite = 1'b0; rst_n = 1'b1;
        for (int i = 1; i < 32; i++) begin
            Dbg_idx = 5'(i);
            #1;
            expect_val($sformatf("sweep_r%0d", i), 32'd0);
            chk(Dbg_data);
        end

        n_assert++;
        assert (val_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", val_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/grf.md
Name: grf

Overview:
- 32 x 32-bit general register file for the single-cycle MIPS datapath.
- Consumes the write-destination index from the register-destination mux and the write-back word from the data-to-register mux.
- Produces the two operand words: rs feeds the ALU A input; rt feeds the ALU source mux and the store-data path.
- Writes commit on the rising clock edge. Reads are combinational, with same-cycle write-through bypass.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH_LOG2, 5, register index width; holds 2**DEPTH_LOG2 registers.
- BYPASS, 1, 1 = a read of the register being written in this cycle returns the write data; 0 = returns the stored (old) value.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RegWrite  in  1  write enable from the control unit.
- Reg_rs  in  5  read port A index (instr[25:21]).
- Reg_rt  in  5  read port B index (instr[20:16]).
- Reg_rd  in  5  write index (register-destination mux output).
- WData  in  WIDTH  write-back data (data-to-register mux output).
- RData1  out  WIDTH  contents of Reg_rs.
- RData2  out  WIDTH  contents of Reg_rt.
- Dbg_idx  in  5  debug read index (testbench and console).
- Dbg_data  out  WIDTH  contents of Dbg_idx, never bypassed.
- WB_valid  out  1  registered pulse: a write committed on the previous edge.
- WB_idx  out  5  registered index of the last committed write.
- WB_data  out  WIDTH  registered data of the last committed write.

Behaviour:
- Storage: regs[0..31], WIDTH bits each.
- Reset (rst_n low, asynchronous):
  - all regs cleared to 0.
  - WB_valid=0, WB_idx=0, WB_data=0.
  - RData1/RData2/Dbg_data read 0 while reset is held.
  - Reset deassertion takes effect at the next rising edge. No write occurs on an edge where rst_n is low.
- Write, rising edge with rst_n=1:
  - If RegWrite=1 and Reg_rd!=0: regs[Reg_rd] <= WData, and WB_valid<=1, WB_idx<=Reg_rd, WB_data<=WData.
  - Otherwise regs are unchanged and WB_valid<=0. WB_idx and WB_data hold their values.
- Register $0:
  - Always reads 0.
  - A write to index 0 is discarded and produces no WB_valid pulse.
- Read, combinational, zero latency:
  - RDataN = 0 when the index is 0.
  - Else, when BYPASS=1 and RegWrite=1 and index==Reg_rd: RDataN = WData.
  - Else RDataN = regs[index].
- Simultaneous events:
  - Both read ports may address the same register, or both may match Reg_rd; each port resolves independently under the rule above.
- X-safety: RegWrite=X or Reg_rd=X must not corrupt more than the addressed register. Simulation checks flag RegWrite=X outside reset.
- Write latency: a value is visible on the non-bypassed path one edge after commit.
- No read-port side effects. Index widths are fixed at DEPTH_LOG2, so out-of-range indices are impossible.

Test Plan:
- Reset: rst_n=0 mid-run after writing regs[5]=0x1234 -> RData1 with Reg_rs=5 reads 0 immediately, before any edge; WB_valid=0.
- Basic write/read: RegWrite=1, Reg_rd=8, WData=0xDEADBEEF, one edge, then RegWrite=0 and Reg_rs=8, Reg_rt=8 -> RData1=RData2=0xDEADBEEF; WB_valid=1 for exactly one cycle with WB_idx=8.
- $0 protection: RegWrite=1, Reg_rd=0, WData=0xFFFFFFFF, one edge -> RData1 (Reg_rs=0)=0, Dbg_data(0)=0, WB_valid=0.
- Bypass: regs[3]=0x11; in the same cycle RegWrite=1, Reg_rd=3, WData=0x22, Reg_rs=3 -> RData1=0x22 before the edge, Dbg_data(3)=0x11. Repeat with BYPASS=0 -> RData1=0x11.
- Back-to-back writes: edges writing r1=1, r1=2, r2=3 -> r1=2, r2=3; WB_valid stays high for three consecutive cycles with WB_idx sequence 1,1,2.
- Asynchronous reset pulse between edges during RegWrite=1 -> no write on the next edge while low; all 31 registers read 0 via the Dbg sweep.
